// File: rtl/plab2_proc_imul_arbiter_pkg.sv
// Shared imul/muldiv message definitions plus the arbiter state encoding.
//   MULDIV_*       : request/response field widths and function codes
//   muldiv_req_t   : packed request layout {func, a, b}
//   IMUL_ARB_*     : arbiter FSM state encodings
//   mk_muldiv_req  : helper that packs a request message
package plab2_proc_imul_arbiter_pkg;

  localparam int unsigned MULDIV_FUNC_NBITS = 3;
  localparam int unsigned MULDIV_DATA_NBITS = 32;
  localparam int unsigned MULDIV_REQ_NBITS  = MULDIV_FUNC_NBITS + 2 * MULDIV_DATA_NBITS;
  localparam int unsigned MULDIV_RESP_NBITS = MULDIV_DATA_NBITS;

  localparam logic [2:0] MULDIV_FUNC_MUL  = 3'd0;
  localparam logic [2:0] MULDIV_FUNC_DIV  = 3'd1;
  localparam logic [2:0] MULDIV_FUNC_DIVU = 3'd2;
  localparam logic [2:0] MULDIV_FUNC_REM  = 3'd3;
  localparam logic [2:0] MULDIV_FUNC_REMU = 3'd4;

  typedef struct packed {
    logic [2:0]  func;
    logic [31:0] a;
    logic [31:0] b;
  } muldiv_req_t;

  localparam logic [1:0] IMUL_ARB_IDLE  = 2'd0;
  localparam logic [1:0] IMUL_ARB_ISSUE = 2'd1;
  localparam logic [1:0] IMUL_ARB_WAIT  = 2'd2;

  function automatic muldiv_req_t mk_muldiv_req(input logic [2:0]  func,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
    muldiv_req_t r;
    r.func = func;
    r.a    = a;
    r.b    = b;
    return r;
  endfunction

endpackage

// File: rtl/plab2_proc_imul_arbiter_rr_arb2.sv
// Two-way round-robin winner select.
//   req   : per-requester valid bits
//   prio  : one-hot, names the requester that wins a tie
//   grant : one-hot winner (all-zero when nobody requests)
module plab2_proc_RrArb2 (
  input  logic [1:0] req,
  input  logic [1:0] prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = prio[1] ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/plab2_proc_imul_arbiter.sv
// Shares one variable-latency multiplier between two requesters, one
// transaction at a time, with round-robin fairness and domain tagging.
//   clk, reset                : clock, async active-low reset
//   reqN_val/rdy/msg/domain   : request ports of requester N
//   respN_val/rdy/msg         : response ports of requester N
//   mul_req_*                 : request port toward the multiplier
//   mul_resp_*                : response port from the multiplier
//   mul_domain                : domain of the current owner
//
// state | meaning
// IDLE  | pick a winner and accept its request into the buffer
// ISSUE | present buffered request to the multiplier
// WAIT  | forward multiplier response to the owner
module plab2_proc_imul_arbiter
  import plab2_proc_imul_arbiter_pkg::*;
#(
  parameter int p_req_nbits  = MULDIV_REQ_NBITS,
  parameter int p_resp_nbits = MULDIV_RESP_NBITS
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    req0_val,
  output logic                    req0_rdy,
  input  logic [p_req_nbits-1:0]  req0_msg,
  input  logic                    req0_domain,
  input  logic                    req1_val,
  output logic                    req1_rdy,
  input  logic [p_req_nbits-1:0]  req1_msg,
  input  logic                    req1_domain,

  output logic                    resp0_val,
  input  logic                    resp0_rdy,
  output logic [p_resp_nbits-1:0] resp0_msg,
  output logic                    resp1_val,
  input  logic                    resp1_rdy,
  output logic [p_resp_nbits-1:0] resp1_msg,

  output logic                    mul_req_val,
  input  logic                    mul_req_rdy,
  output logic [p_req_nbits-1:0]  mul_req_msg,
  input  logic                    mul_resp_val,
  output logic                    mul_resp_rdy,
  input  logic [p_resp_nbits-1:0] mul_resp_msg,
  output logic                    mul_domain
);

  logic [1:0]             state_q, state_d;
  logic                   prio_q, prio_d;
  logic                   owner_q, owner_d;
  logic [p_req_nbits-1:0] buf_msg_q, buf_msg_d;
  logic                   buf_dom_q, buf_dom_d;

  logic [1:0] arb_req, arb_prio, arb_grant;
  logic       in_idle, in_issue, in_wait;
  logic       req_hs, resp_hs, owner_resp_rdy;

  assign arb_req  = {req1_val, req0_val};
  assign arb_prio = prio_q ? 2'b10 : 2'b01;

  plab2_proc_RrArb2 u_rr_arb (
    .req   (arb_req),
    .prio  (arb_prio),
    .grant (arb_grant)
  );

  assign in_idle  = (state_q == IMUL_ARB_IDLE);
  assign in_issue = (state_q == IMUL_ARB_ISSUE);
  assign in_wait  = (state_q == IMUL_ARB_WAIT);

  // rdy is masked by reset so nothing looks accepted while reset is held
  assign req0_rdy = reset & in_idle & arb_grant[0];
  assign req1_rdy = reset & in_idle & arb_grant[1];
  assign req_hs   = in_idle & (|arb_grant);

  assign owner_resp_rdy = owner_q ? resp1_rdy : resp0_rdy;
  assign mul_resp_rdy   = in_wait & owner_resp_rdy;
  assign resp_hs        = in_wait & mul_resp_val & owner_resp_rdy;

  assign resp0_val = in_wait & ~owner_q & mul_resp_val;
  assign resp1_val = in_wait &  owner_q & mul_resp_val;
  assign resp0_msg = (in_wait & ~owner_q) ? mul_resp_msg : '0;
  assign resp1_msg = (in_wait &  owner_q) ? mul_resp_msg : '0;

  assign mul_req_val = in_issue;
  assign mul_req_msg = buf_msg_q;
  assign mul_domain  = (in_issue | in_wait) & buf_dom_q;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    buf_msg_d = buf_msg_q;
    buf_dom_d = buf_dom_q;
    case (state_q)
      IMUL_ARB_IDLE: begin
        if (req_hs) begin
          owner_d   = arb_grant[1];
          buf_msg_d = arb_grant[1] ? req1_msg : req0_msg;
          buf_dom_d = arb_grant[1] ? req1_domain : req0_domain;
          state_d   = IMUL_ARB_ISSUE;
        end
      end
      IMUL_ARB_ISSUE: begin
        if (mul_req_rdy) state_d = IMUL_ARB_WAIT;
      end
      IMUL_ARB_WAIT: begin
        if (resp_hs) begin
          state_d = IMUL_ARB_IDLE;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = IMUL_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IMUL_ARB_IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      buf_msg_q <= '0;
      buf_dom_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      buf_msg_q <= buf_msg_d;
      buf_dom_q <= buf_dom_d;
    end
  end

endmodule

// File: tb/tb_plab2_proc_imul_arbiter.sv
module tb_plab2_proc_imul_arbiter;

  typedef struct {
    logic [66:0] msg;
    logic        dom;
  } rq_t;

  logic        clk;
  logic        reset;
  logic        req0_val, req0_rdy, req0_domain;
  logic [66:0] req0_msg;
  logic        req1_val, req1_rdy, req1_domain;
  logic [66:0] req1_msg;
  logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [31:0] resp0_msg, resp1_msg;
  logic        mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy, mul_domain;
  logic [66:0] mul_req_msg;
  logic [31:0] mul_resp_msg;

  plab2_proc_imul_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req0_val     (req0_val),
    .req0_rdy     (req0_rdy),
    .req0_msg     (req0_msg),
    .req0_domain  (req0_domain),
    .req1_val     (req1_val),
    .req1_rdy     (req1_rdy),
    .req1_msg     (req1_msg),
    .req1_domain  (req1_domain),
    .resp0_val    (resp0_val),
    .resp0_rdy    (resp0_rdy),
    .resp0_msg    (resp0_msg),
    .resp1_val    (resp1_val),
    .resp1_rdy    (resp1_rdy),
    .resp1_msg    (resp1_msg),
    .mul_req_val  (mul_req_val),
    .mul_req_rdy  (mul_req_rdy),
    .mul_req_msg  (mul_req_msg),
    .mul_resp_val (mul_resp_val),
    .mul_resp_rdy (mul_resp_rdy),
    .mul_resp_msg (mul_resp_msg),
    .mul_domain   (mul_domain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // stimulus queues (front = message currently offered)
  rq_t q0[$];
  rq_t q1[$];

  // bench multiplier and backpressure knobs
  logic        mul_busy = 1'b0;
  int          mul_cnt  = 0;
  logic [31:0] mul_res  = '0;
  int          lat      = 4;
  int          mreq_stall = 0;
  int          rs0_stall  = 0;
  int          rs1_stall  = 0;
  logic        spur       = 1'b0;

  // transaction-level model: owner -1 means no transaction in flight
  int          m_owner = -1;
  logic        m_sent  = 1'b0;
  int          m_prio  = 0;
  logic [66:0] m_msg   = '0;
  logic        m_dom   = 1'b0;

  // DUT-observed events
  int          dgrant[$];
  logic [31:0] got0[$];
  logic [31:0] got1[$];
  int ev_rdy0, ev_mreq, ev_resp0;
  int n_mreq, n_r0v, n_r1v, n_dom;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0b required=%0b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chkm(input string nm, input logic [66:0] act, input logic [66:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int gat(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic rq_t mkr(input logic [31:0] a, input logic [31:0] b, input logic d);
    rq_t r;
    r.msg = {3'd0, a, b};
    r.dom = d;
    return r;
  endfunction

  // one clock of stimulus, driven on the falling edge
  task automatic step();
    @(negedge clk);
    cyc++;
    req0_val    = (q0.size() > 0);
    req0_msg    = req0_val ? q0[0].msg : 67'd0;
    req0_domain = req0_val ? q0[0].dom : 1'b0;
    req1_val    = (q1.size() > 0);
    req1_msg    = req1_val ? q1[0].msg : 67'd0;
    req1_domain = req1_val ? q1[0].dom : 1'b0;
    mul_req_rdy = (mreq_stall == 0);
    if (mul_busy && mul_cnt > 0) mul_cnt--;
    mul_resp_val = (mul_busy && mul_cnt == 0) || (spur && !mul_busy);
    mul_resp_msg = (mul_busy && mul_cnt == 0) ? mul_res : (spur ? 32'hDEAD_BEEF : 32'h0);
    resp0_rdy = (rs0_stall == 0);
    resp1_rdy = (rs1_stall == 0);
  endtask

  // compare DUT to model, then advance model and bench multiplier to the next edge
  always @(negedge clk) begin : cmp
    int   win;
    logic e_r0, e_r1, e_mv, e_dom, e_mrr, e_v0, e_v1, o_rdy;
    logic [31:0] e_m0, e_m1;
    rq_t  r;
    #2;
    if (req0_val && req0_rdy) dgrant.push_back(0);
    if (req1_val && req1_rdy) dgrant.push_back(1);
    if (resp0_val && resp0_rdy) got0.push_back(resp0_msg);
    if (resp1_val && resp1_rdy) got1.push_back(resp1_msg);
    if (req0_rdy && ev_rdy0 < 0) ev_rdy0 = cyc;
    if (mul_req_val && ev_mreq < 0) ev_mreq = cyc;
    if (resp0_val && ev_resp0 < 0) ev_resp0 = cyc;
    n_mreq += int'(mul_req_val);
    n_r0v  += int'(resp0_val);
    n_r1v  += int'(resp1_val);
    n_dom  += int'(mul_domain);

    if (!reset) begin
      chk1("rst_req0_rdy", req0_rdy, 1'b0);
      chk1("rst_req1_rdy", req1_rdy, 1'b0);
      chk1("rst_resp0_val", resp0_val, 1'b0);
      chk1("rst_resp1_val", resp1_val, 1'b0);
      chk1("rst_mul_req_val", mul_req_val, 1'b0);
      chk1("rst_mul_resp_rdy", mul_resp_rdy, 1'b0);
      chk1("rst_mul_domain", mul_domain, 1'b0);
      m_owner  = -1;
      m_sent   = 1'b0;
      m_prio   = 0;
      mul_busy = 1'b0;
      mul_cnt  = 0;
    end else begin
      win = -1;
      {e_r0, e_r1, e_mv, e_dom, e_mrr, e_v0, e_v1, o_rdy} = '0;
      e_m0 = '0;
      e_m1 = '0;
      if (m_owner < 0) begin
        if (req0_val || req1_val)
          win = (req0_val && req1_val) ? m_prio : (req1_val ? 1 : 0);
        e_r0 = (win == 0);
        e_r1 = (win == 1);
      end else if (!m_sent) begin
        e_mv  = 1'b1;
        e_dom = m_dom;
      end else begin
        e_dom = m_dom;
        o_rdy = (m_owner == 1) ? resp1_rdy : resp0_rdy;
        e_mrr = o_rdy;
        if (m_owner == 0) begin
          e_v0 = mul_resp_val;
          e_m0 = mul_resp_msg;
        end else begin
          e_v1 = mul_resp_val;
          e_m1 = mul_resp_msg;
        end
      end
      chk1("req0_rdy", req0_rdy, e_r0);
      chk1("req1_rdy", req1_rdy, e_r1);
      chk1("mul_req_val", mul_req_val, e_mv);
      chk1("mul_domain", mul_domain, e_dom);
      chk1("mul_resp_rdy", mul_resp_rdy, e_mrr);
      chk1("resp0_val", resp0_val, e_v0);
      chk1("resp1_val", resp1_val, e_v1);
      if (m_owner >= 0 && m_sent) begin
        chk32("resp0_msg", resp0_msg, e_m0);
        chk32("resp1_msg", resp1_msg, e_m1);
      end
      if (m_owner >= 0 && !m_sent) chkm("mul_req_msg", mul_req_msg, m_msg);

      if (m_owner < 0) begin
        if (win >= 0) begin
          r = (win == 1) ? q1.pop_front() : q0.pop_front();
          m_owner = win;
          m_sent  = 1'b0;
          m_msg   = r.msg;
          m_dom   = r.dom;
        end
      end else if (!m_sent) begin
        if (mul_req_rdy) m_sent = 1'b1;
        else if (mreq_stall > 0) mreq_stall--;
      end else begin
        if (mul_resp_val && o_rdy) begin
          m_prio  = 1 - m_owner;
          m_owner = -1;
        end else if (mul_resp_val) begin
          if (m_owner == 0 && rs0_stall > 0) rs0_stall--;
          if (m_owner == 1 && rs1_stall > 0) rs1_stall--;
        end
      end

      // bench multiplier reacts to what the DUT actually presents
      if (mul_req_val && mul_req_rdy && !mul_busy) begin
        mul_busy = 1'b1;
        mul_cnt  = lat;
        mul_res  = mul_req_msg[63:32] * mul_req_msg[31:0];
      end else if (mul_busy && mul_resp_val && mul_resp_rdy) begin
        mul_busy = 1'b0;
      end
    end
  end

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((q0.size() > 0 || q1.size() > 0 || m_owner >= 0) && n < budget);
    #3;
    chki({nm, "_timeout"}, int'(q0.size() > 0 || q1.size() > 0 || m_owner >= 0), 0);
  endtask

  task automatic clear_obs();
    dgrant.delete();
    got0.delete();
    got1.delete();
    ev_rdy0 = -1; ev_mreq = -1; ev_resp0 = -1;
    n_mreq = 0; n_r0v = 0; n_r1v = 0; n_dom = 0;
    cyc = -1;
  endtask

  task automatic do_reset();
    step();
    #1 reset = 1'b0;
    q0.delete();
    q1.delete();
    step();
    step();
    step();
    #1 reset = 1'b1;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    {req0_val, req0_domain, req1_val, req1_domain} = '0;
    req0_msg = '0; req1_msg = '0;
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    mul_req_rdy = 1'b1; mul_resp_val = 1'b0; mul_resp_msg = '0;
    clear_obs();
    repeat (2) step();
    #1 reset = 1'b1;

    // single request, latency 4
    clear_obs();
    lat = 4;
    q0.push_back(mkr(32'd3, 32'd5, 1'b0));
    wait_done("s1", 40);
    chki("s1_req0_rdy_cycle", ev_rdy0, 0);
    chki("s1_mul_req_val_cycle", ev_mreq, 1);
    chki("s1_resp0_val_cycle", ev_resp0, 5);
    chk32("s1_product", qat(got0, 0), 32'd15);
    chki("s1_resp1_val_cycles", n_r1v, 0);

    // simultaneous requests after reset
    do_reset();
    clear_obs();
    lat = 3;
    q0.push_back(mkr(32'd2, 32'd7, 1'b0));
    q1.push_back(mkr(32'd4, 32'd4, 1'b1));
    wait_done("s2", 60);
    chki("s2_first_grant", gat(dgrant, 0), 0);
    chki("s2_second_grant", gat(dgrant, 1), 1);
    chk32("s2_prod0", qat(got0, 0), 32'd14);
    chk32("s2_prod1", qat(got1, 0), 32'd16);

    // continuous contention, six transactions; first grant to 0 shows prio back at 0
    clear_obs();
    lat = 1;
    q0.push_back(mkr(32'd1, 32'd2, 1'b0));
    q0.push_back(mkr(32'd3, 32'd4, 1'b0));
    q0.push_back(mkr(32'd5, 32'd6, 1'b0));
    q1.push_back(mkr(32'd7, 32'd8, 1'b1));
    q1.push_back(mkr(32'd9, 32'd10, 1'b1));
    q1.push_back(mkr(32'd11, 32'd12, 1'b1));
    wait_done("s3", 100);
    chki("s3_grants", dgrant.size(), 6);
    for (int i = 0; i < 6; i++) chki("s3_grant_order", gat(dgrant, i), i % 2);
    chk32("s3_prod0_last", qat(got0, 2), 32'd30);
    chk32("s3_prod1_last", qat(got1, 2), 32'd132);

    // backpressure on both multiplier request and owner response, with stray mul_resp_val
    clear_obs();
    lat = 2;
    mreq_stall = 3;
    rs1_stall  = 2;
    spur = 1'b1;
    q1.push_back(mkr(32'd6, 32'd7, 1'b1));
    wait_done("s4", 60);
    spur = 1'b0;
    chk32("s4_product", qat(got1, 0), 32'd42);
    chki("s4_mul_req_val_cycles", n_mreq, 4);
    chki("s4_resp1_val_cycles", n_r1v, 3);
    chki("s4_mul_domain_cycles", n_dom, 8);
    chki("s4_resp0_val_cycles", n_r0v, 0);

    // reset in WAIT with prio pointing at requester 1
    clear_obs();
    lat = 6;
    q0.push_back(mkr(32'd1, 32'd1, 1'b0));
    q0.push_back(mkr(32'd9, 32'd9, 1'b0));
    n = 0;
    while (!(got0.size() >= 1 && m_owner == 0 && m_sent) && n < 80) begin
      step();
      n++;
    end
    chki("s5_reach_wait", int'(got0.size() >= 1 && m_owner == 0 && m_sent), 1);
    #1 reset = 1'b0;
    q0.delete();
    q1.delete();
    #2;
    chk1("s5_mul_domain_in_reset", mul_domain, 1'b0);
    chk1("s5_mul_resp_rdy_in_reset", mul_resp_rdy, 1'b0);
    step();
    step();
    #1 reset = 1'b1;
    clear_obs();
    lat = 2;
    q0.push_back(mkr(32'd1, 32'd1, 1'b0));
    q1.push_back(mkr(32'd5, 32'd3, 1'b1));
    wait_done("s5", 60);
    chki("s5_first_grant_after_reset", gat(dgrant, 0), 0);
    chki("s5_second_grant_after_reset", gat(dgrant, 1), 1);
    chk32("s5_prod1", qat(got1, 0), 32'd15);
    chk32("s5_prod0", qat(got0, 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

endmodule

// File: doc/plab2_proc_imul_arbiter.md
PLAB2_PROC_IMUL_ARBITER -- requirements
Module: plab2_proc_imul_arbiter

Interface
REQ-001 Parameter p_req_nbits, default 67, width of a multiply request message (func + a + b).
REQ-002 Parameter p_resp_nbits, default 32, width of a multiply response message.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 req0_val / req1_val  input  1  requester n has a multiply request.
REQ-006 req0_rdy / req1_rdy  output  1  arbiter accepts requester n's message this cycle.
REQ-007 req0_msg / req1_msg  input  p_req_nbits  requester n's request message.
REQ-008 req0_domain / req1_domain  input  1  security domain of requester n.
REQ-009 resp0_val / resp1_val  output  1  response valid to requester n.
REQ-010 resp0_rdy / resp1_rdy  input  1  requester n accepts its response.
REQ-011 resp0_msg / resp1_msg  output  p_resp_nbits  response data to requester n.
REQ-012 mul_req_val, mul_req_rdy, mul_req_msg  output/input/output  1/1/p_req_nbits  request port to the shared variable-latency multiplier.
REQ-013 mul_resp_val, mul_resp_rdy, mul_resp_msg  input/output/input  1/1/p_resp_nbits  response port from the multiplier.
REQ-014 mul_domain  output  1  domain of the current owner; drives the multiplier's domain input.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE and WAIT; exactly one transaction is outstanding at a time.
REQ-016 In IDLE, the winner SHALL be the requester with val set; if both are set, it is the requester named by the priority pointer prio (reset 0).
REQ-017 In IDLE, the arbiter SHALL assert reqN_rdy for the winner only. On that handshake it SHALL capture msg and domain into an internal buffer, record owner=N and go to ISSUE.
REQ-018 In ISSUE, mul_req_val SHALL be 1 and mul_req_msg SHALL be the buffered message. On mul_req_rdy it SHALL go to WAIT; with no rdy it stays in ISSUE with the message held stable.
REQ-019 A request accepted in cycle t SHALL appear as mul_req_val in cycle t+1 at the earliest.
REQ-020 In WAIT, respN_val and respN_msg for the owner SHALL equal mul_resp_val and mul_resp_msg combinationally, and mul_resp_rdy SHALL equal respN_rdy of the owner.
REQ-021 On the owner's response handshake in WAIT, the FSM SHALL return to IDLE and set prio to the non-owner.
REQ-022 The non-owner's resp_val SHALL always be 0 and its resp_msg all-zero. Both req_rdy outputs SHALL be 0 outside IDLE.
REQ-023 mul_resp_rdy SHALL be 0 in IDLE and ISSUE; mul_resp_val arriving then is ignored.
REQ-024 mul_domain SHALL equal the buffered owner domain in ISSUE and WAIT, and 0 in IDLE.
REQ-025 A requester holding val across a transaction SHALL be considered again in the next IDLE cycle. Two-requester round robin guarantees service within 2 transactions.
REQ-026 Minimum occupancy per transaction SHALL be 3 cycles (IDLE, ISSUE, WAIT) with no back-to-back accept.

Reset
REQ-027 Asserting reset SHALL immediately force state=IDLE, prio=0, owner=0, buffer=0, and all val/rdy outputs to 0, including mid-ISSUE or mid-WAIT.
REQ-028 An in-flight multiplier transaction at reset SHALL be abandoned; the multiplier is reset by the same signal.

Structure
REQ-029 State encodings and the request/response widths SHALL live in the shared imul message package alongside the existing MulDiv message definitions.
REQ-030 Winner selection SHALL be a single sub-module plab2_proc_RrArb2: inputs 2-bit req and prio, output one-hot grant.
REQ-031 All state registers SHALL be explicit asynchronous-reset registers; output steering is combinational from state and owner.

Verification
REQ-032 Single request: req0_val=1 with a=3, b=5, multiplier latency 4 -> req0_rdy in cycle 0, mul_req_val in cycle 1, resp0_val with msg=15 in cycle 5, resp1_val=0 throughout.
REQ-033 Simultaneous requests after reset: req0 (a=2, b=7) and req1 (a=4, b=4) -> req0 served first (14), then req1 (16), prio=0 at the end.
REQ-034 Continuous contention for 6 transactions -> grants alternate 0,1,0,1,0,1; no requester is granted twice in a row.
REQ-035 Backpressure: mul_req_rdy low 3 cycles, then resp1_rdy low 2 cycles -> mul_req_msg stable, resp1_val held, mul_resp_rdy=0 until resp1_rdy rises.
REQ-036 Reset asserted in WAIT -> next cycle state IDLE, all val/rdy 0, prio 0, and a fresh req1 is granted normally after release.
REQ-037 Domain isolation: req1_domain=1, req0_domain=0 -> mul_domain=1 only while owner=1, and resp0_val never asserts during owner=1.
